// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM states,
// op encodings, the iteration count and a magnitude helper.
package muldiv_pkg;

   localparam int ITERATIONS = 32;
   localparam int CNT_W      = $clog2(ITERATIONS);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_DIV   = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      RUN,
      FIX,
      DONE
   } state_t;

   // Two's-complement absolute value, only applied when the operation is signed.
   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
      return (isSigned && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and muldiv_seq (slave).
interface muldiv_seq_if;

   logic        start;
   logic [1:0]  op;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        hilo_wr;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, flush, a, b,
      input  busy, done, div_zero, hilo_wr, hi, lo
   );

   modport slave (
      input  start, op, flush, a, b,
      output busy, done, div_zero, hilo_wr, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: left shift, then either a
// conditional add (multiply) or a restoring trial subtract (divide).
module muldiv_step (
   input  logic        i_isDiv,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_q,
   input  logic [31:0] i_d,
   output logic [63:0] o_acc,
   output logic [31:0] o_q
);

   logic [63:0] w_shiftAcc;
   logic [32:0] w_shiftRem;
   logic [32:0] w_diff;
   logic        w_fits;

   // Divide keeps the remainder in acc[31:0] and shifts dividend bits in from q.
   always_comb begin
      w_shiftAcc = {i_acc[62:0], 1'b0};
      w_shiftRem = {i_acc[31:0], i_q[31]};
      w_fits     = (w_shiftRem >= {1'b0, i_d});
      w_diff     = w_shiftRem - {1'b0, i_d};
      o_acc      = w_shiftAcc;
      o_q        = {i_q[30:0], 1'b0};
      if (i_isDiv) begin
         if (w_fits) begin
            o_acc = {31'd0, w_diff};
            o_q   = {i_q[30:0], 1'b1};
         end else begin
            o_acc = {31'd0, w_shiftRem};
         end
      end else if (i_q[31]) begin
         o_acc = w_shiftAcc + {32'd0, i_d};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide, one bit per cycle, 35-cycle latency.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise every op is unsigned.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   muldiv_seq_if.slave bus
);

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_count;
   logic              r_isDiv;
   logic              r_isSigned;
   logic              r_negRes;
   logic              r_negRem;
   logic              r_divZero;
   logic [63:0]       r_acc;
   logic [31:0]       r_q;
   logic [31:0]       r_d;
   logic [31:0]       r_hi;
   logic [31:0]       r_lo;
   logic [63:0]       w_stepAcc;
   logic [31:0]       w_stepQ;
   logic              w_reqSigned;
   logic              w_reqDivZero;

   always_comb begin
`ifdef MULDIV_SIGNED_EN
      w_reqSigned = ~bus.op[1];
`else
      w_reqSigned = 1'b0;
`endif
      w_reqDivZero = bus.op[0] && (bus.b == 32'd0);
   end

   muldiv_step u_step (
      .i_isDiv (r_isDiv),
      .i_acc   (r_acc),
      .i_q     (r_q),
      .i_d     (r_d),
      .o_acc   (w_stepAcc),
      .o_q     (w_stepQ)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Flush wins over everything; start only matters in IDLE.
   always_comb begin
      w_nextState = r_state;
      if (bus.flush) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (bus.start) w_nextState = w_reqDivZero ? DONE : PREP;
            PREP:    w_nextState = RUN;
            RUN:     if (r_count == '0) w_nextState = FIX;
            FIX:     w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // For multiply q holds the multiplier and d the multiplicand; for divide
   // q holds the dividend (becoming the quotient) and d the divisor.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_isDiv    <= 1'b0;
         r_isSigned <= 1'b0;
         r_negRes   <= 1'b0;
         r_negRem   <= 1'b0;
         r_divZero  <= 1'b0;
         r_acc      <= '0;
         r_q        <= '0;
         r_d        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else if (!bus.flush) begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_isDiv    <= bus.op[0];
                  r_isSigned <= w_reqSigned;
                  r_divZero  <= w_reqDivZero;
                  r_q        <= bus.op[0] ? bus.a : bus.b;
                  r_d        <= bus.op[0] ? bus.b : bus.a;
               end
            end
            PREP: begin
               r_negRes <= r_isSigned & (r_q[31] ^ r_d[31]);
               r_negRem <= r_isSigned & r_isDiv & r_q[31];
               r_q      <= magnitude(r_q, r_isSigned);
               r_d      <= magnitude(r_d, r_isSigned);
               r_acc    <= '0;
               r_count  <= LAST_COUNT;
            end
            RUN: begin
               r_acc <= w_stepAcc;
               r_q   <= w_stepQ;
               if (r_count != '0) r_count <= r_count - CNT_W'(1);
            end
            FIX: begin
               if (r_isDiv) begin
                  r_lo <= r_negRes ? -r_q : r_q;
                  r_hi <= r_negRem ? -r_acc[31:0] : r_acc[31:0];
               end else begin
                  {r_hi, r_lo} <= r_negRes ? -r_acc : r_acc;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.hilo_wr  = 1'b0;
      bus.div_zero = 1'b0;
      case (r_state)
         PREP, RUN, FIX: bus.busy = 1'b1;
         DONE: begin
            bus.done     = 1'b1;
            bus.hilo_wr  = ~r_divZero;
            bus.div_zero = r_divZero;
         end
         default: ;
      endcase
   end

   assign bus.hi = r_hi;
   assign bus.lo = r_lo;

endmodule
